// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART byte transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 260;
    localparam int FIFO_DEPTH_DEF   = 4;
    localparam int TIMER_W          = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART serializer. The head byte is presented on rdata;
// pop advances it. A push is ignored when full and a pop is ignored when empty.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Fullness is judged on the registered count, so a same-cycle pop never frees room for a push.
    always_comb begin
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// Buffered 8N1 UART transmitter: strobed bytes queue in a FIFO and go out back to back.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       fifo_full,
    output logic       tx_done,
    output logic       overflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TIMER_W-1:0] BIT_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    tx_state_e          state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               txd_q, txd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full_w;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             bit_end;

    assign fifo_push = tx_start & ~fifo_full_w;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .wdata (tx_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full_w),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end = (timer_q == BIT_LAST);

    // The line register lags the state by one cycle, which gives the two-edge strobe-to-start latency.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        txd_d      = 1'b1;
        done_d     = 1'b0;
        fifo_pop   = 1'b0;
        overflow_d = overflow_q | (tx_start & fifo_full_w);
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_rdata;
`endif
                    timer_d  = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                txd_d = 1'b0;
                if (bit_end) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DATA: begin
                txd_d = shift_q[0];
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                txd_d = parity_q;
                if (bit_end) begin
                    timer_d = '0;
                    state_d = ST_STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    done_d  = 1'b1;
                    timer_d = '0;
                    // Chain straight into the next start bit so queued bytes leave without an idle gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_rdata;
`endif
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        // Stays high through the final stop-bit cycle still being driven by txd_q.
        busy_d = (fifo_count != '0) || fifo_push ||
                 (state_q != ST_IDLE) || (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign uart_txd  = txd_q;
    assign tx_busy   = busy_q;
    assign fifo_full = fifo_full_w;
    assign tx_done   = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Testbench for uart_byte_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4: a line decoder feeds a
// byte scoreboard, with directed sequences for latency, chaining, overflow and reset.
module tb_uart_byte_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * CPB;

    logic       clk;
    logic       rstn;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       uart_txd;
    logic       tx_busy;
    logic       fifo_full;
    logic       tx_done;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries are {expected parity, expected byte}.
    logic [8:0] exp_q[$];

    uart_byte_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .uart_txd  (uart_txd),
        .tx_busy   (tx_busy),
        .fifo_full (fifo_full),
        .tx_done   (tx_done),
        .overflow  (overflow)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line decoder: a start bit is the first low negedge sample while idle; bits are read mid-cell.
    int         mon_cnt = 0;
    bit         mon_active = 0;
    logic [7:0] mon_byte;
    logic       mon_par;
    int         done_cnt = 0;

    always @(negedge clk) begin
        bit         at_end;
        int         b;
        logic [8:0] e;
        at_end = 0;
        if (!rstn) begin
            mon_active = 0;
            mon_cnt    = 0;
        end else begin
            if (mon_active) begin
                mon_cnt++;
            end else if (uart_txd == 1'b0) begin
                mon_active = 1;
                mon_cnt    = 0;
            end
            if (mon_active) begin
                if (mon_cnt % CPB == CPB / 2) begin
                    b = mon_cnt / CPB;
                    if (b == 0) begin
                        chk("start_bit", uart_txd, 1'b0);
                    end else if (b <= 8) begin
                        mon_byte[b-1] = uart_txd;
                    end else if (b < FB - 1) begin
                        mon_par = uart_txd;
                    end else begin
                        chk("stop_bit", uart_txd, 1'b1);
                        if (exp_q.size() == 0) begin
                            chk("rx_unexpected", {24'd0, mon_byte}, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            chk("rx_byte", mon_byte, e[7:0]);
`ifdef UART_TX_PARITY_EN
                            chk("rx_parity", mon_par, e[8]);
`endif
                        end
                    end
                end
                if (mon_cnt == FRAME - 1) begin
                    at_end     = 1;
                    mon_active = 0;
                    chk("tx_done_end", tx_done, 1'b1);
                end
            end
            if (tx_done) begin
                done_cnt++;
                if (!at_end) chk("tx_done_spurious", tx_done, 1'b0);
            end
        end
    end

    // Driver tasks
    task automatic strobe(input logic [7:0] b, input logic par, input bit accept);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        if (accept) exp_q.push_back({par, b});
    endtask

    task automatic release_start();
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = $urandom_range(0, 255);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_busy && n < budget);
        if (tx_busy) chk("idle_timeout", tx_busy, 1'b0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [FB-1:0] a5_bits;
        bit            bad;
        int            d0;
        int            hi_cnt;
        logic [7:0]    b;

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'hFA, 1'b0};
        vecs[2] = '{8'hF1, 1'b1};
        vecs[3] = '{8'h07, 1'b1};
        vecs[4] = '{8'h03, 1'b0};
        vecs[5] = '{8'h00, 1'b0};
        vecs[6] = '{8'hFF, 1'b0};
        vecs[7] = '{8'h80, 1'b1};
`ifdef UART_TX_PARITY_EN
        a5_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
        a5_bits = {1'b1, 8'hA5, 1'b0};
`endif

        rstn     = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_txd", uart_txd, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5: start bit falls two edges after the strobe, then the exact bit pattern.
        d0 = done_cnt;
        strobe(8'hA5, 1'b0, 1);
        release_start();
        chk("lat_txd_e0", uart_txd, 1'b1);
        chk("lat_busy_e0", tx_busy, 1'b1);
        @(negedge clk);
        chk("lat_txd_e1", uart_txd, 1'b1);
        @(negedge clk);
        for (int bi = 0; bi < FB; bi++) begin
            bad = 0;
            for (int c = 0; c < CPB; c++) begin
                if (bi != 0 || c != 0) @(negedge clk);
                if (uart_txd !== a5_bits[bi]) bad = 1;
            end
            chk($sformatf("a5_bit%0d", bi), {31'd0, bad}, 32'd0);
        end
        chk("a5_done_last", tx_done, 1'b1);
        wait_idle(200);
        chk("a5_done_cnt", done_cnt - d0, 1);

        // Table of single bytes
        for (int i = 0; i < 8; i++) begin
            d0 = done_cnt;
            strobe(vecs[i].data, vecs[i].par, 1);
            release_start();
            wait_idle(200);
            chk($sformatf("vec%0d_done", i), done_cnt - d0, 1);
            chk($sformatf("vec%0d_ovf", i), overflow, 1'b0);
        end

        // Back-to-back pair: contiguous frames, busy held across both.
        d0 = done_cnt;
        strobe(8'hFA, 1'b0, 1);
        strobe(8'hF1, 1'b1, 1);
        release_start();
        chk("pair_busy", tx_busy, 1'b1);
        hi_cnt = 2;
        for (int n = 0; n < 4 * FRAME; n++) begin
            @(negedge clk);
            if (!tx_busy) break;
            hi_cnt++;
        end
        chk("pair_busy_len", hi_cnt, 2 + 2 * FRAME);
        chk("pair_done_cnt", done_cnt - d0, 2);

        // Six consecutive strobes into a depth-4 FIFO: the sixth is dropped.
        d0 = done_cnt;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 5) begin
                chk("burst_full_pre", fifo_full, 1'b1);
                chk("burst_ovf_pre", overflow, 1'b0);
            end
            b = 8'h10 + 8'(k);
            tx_data  = b;
            tx_start = 1'b1;
            if (k < 5) exp_q.push_back({^b, b});
        end
        release_start();
        chk("burst_ovf", overflow, 1'b1);
        chk("burst_full", fifo_full, 1'b1);
        wait_idle(1000);
        chk("burst_done_cnt", done_cnt - d0, 5);
        chk("burst_ovf_sticky", overflow, 1'b1);
        chk("burst_full_after", fifo_full, 1'b0);

        // Reset asserted mid-DATA between clock edges.
        strobe(8'h3C, 1'b0, 1);
        release_start();
        repeat (8) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_txd", uart_txd, 1'b1);
        chk("arst_busy", tx_busy, 1'b0);
        chk("arst_full", fifo_full, 1'b0);
        chk("arst_done", tx_done, 1'b0);
        chk("arst_ovf", overflow, 1'b0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) begin
            @(negedge clk);
            chk("arst_no_done", tx_done, 1'b0);
        end
        rstn = 1'b1;
        strobe(8'h55, 1'b0, 1);
        release_start();
        wait_idle(200);
        chk("post_rst_done_cnt", done_cnt - d0, 1);

        // Upstream-like stream: strobes spaced just over one frame time.
        d0 = done_cnt;
        for (int i = 0; i < 132; i++) begin
            if (i == 0 || i == 131) b = 8'hFA;
            else if (i == 1 || i == 130) b = 8'hF1;
            else b = 8'($urandom_range(0, 255));
            strobe(b, ^b, 1);
            release_start();
            repeat (FRAME - 1) @(negedge clk);
        end
        wait_idle(4 * FRAME);
        chk("stream_done_cnt", done_cnt - d0, 132);
        chk("stream_ovf", overflow, 1'b0);
        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 260, clk cycles per serial bit (25 MHz / 96000 baud); legal range 2..4095.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte-FIFO entries; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port tx_data  input  8  byte to send, sampled only when tx_start=1.
REQ-006 SHALL have port tx_start  input  1  single-cycle write strobe; connects to the upstream uart_done.
REQ-007 SHALL have port uart_txd  output  1  serial line, idle high.
REQ-008 SHALL have port tx_busy  output  1  high while the FIFO is non-empty or a frame is on the line.
REQ-009 SHALL have port fifo_full  output  1  high when FIFO holds FIFO_DEPTH bytes.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.
REQ-011 SHALL have port overflow  output  1  sticky flag: a strobed byte was dropped.

Function
REQ-012 SHALL push tx_data into the FIFO at an edge where tx_start=1 and fifo_full=0; FIFO order preserved.
REQ-013 SHALL drop the byte and set overflow at an edge where tx_start=1 and fifo_full=1; fullness is evaluated before any same-cycle pop.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, plus PARITY only when the macro in REQ-024 is defined.
REQ-015 IDLE: pop the FIFO head into a shift register when the FIFO is non-empty and go to START; otherwise stay in IDLE with uart_txd=1.
REQ-016 Latency: if tx_start is sampled at edge E into an empty FIFO with the FSM in IDLE, uart_txd SHALL fall at edge E+2.
REQ-017 SHALL hold each bit for exactly CLKS_PER_BIT cycles using a 12-bit bit-timer that reloads at each bit boundary.
REQ-018 Frame: start bit 0, 8 data bits LSB first, optional parity bit, stop bit 1.
REQ-019 DATA SHALL use a 3-bit bit index and leave after index 7 completes.
REQ-020 At the end of STOP, SHALL pulse tx_done and go directly to START with the next popped byte if the FIFO is non-empty, with no idle bit between frames; otherwise go to IDLE.
REQ-021 fifo_full and tx_busy SHALL be registered-consistent with the FIFO count after each edge; the count never exceeds FIFO_DEPTH or goes below 0.
REQ-022 Default frame time is 10*260 = 2600 cycles, which is below the 2605-cycle upstream byte spacing; the FIFO absorbs the upstream back-to-back pair (READ immediately followed by OVER0).

Reset
REQ-023 On rstn=0, asynchronously: uart_txd=1, tx_busy=0, fifo_full=0, tx_done=0, overflow=0, FIFO emptied, FSM=IDLE, timers=0; a frame in progress is aborted with no completion pulse.

Configuration
REQ-024 Macro UART_TX_PARITY_EN: when defined, a PARITY state after DATA SHALL transmit the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, making frames 11 bits; when undefined, no PARITY state or logic is built and frames are 10 bits.

Structure
REQ-025 Shared package uart_pkg SHALL hold the FSM state enum, the default CLKS_PER_BIT/FIFO_DEPTH constants, and the 12-bit timer width.
REQ-026 The FIFO SHALL be a separate sub-module uart_tx_fifo with push/pop/full/empty/count, instantiated once.

Verification
REQ-027 CLKS_PER_BIT=4: strobe 0xA5 -> uart_txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, start bit at E+2, tx_done once.
REQ-028 Strobe 0xFA then 0xF1 on consecutive cycles -> two contiguous frames with no idle gap, two tx_done pulses, tx_busy low only after the second stop bit.
REQ-029 FIFO_DEPTH=4: 6 strobes on consecutive cycles -> first 5 bytes sent in order (one popped before the 6th strobe, FIFO then full), 6th dropped, overflow=1 and it stays 1 until reset.
REQ-030 UART_TX_PARITY_EN defined: strobe 0x07 -> parity bit 1; strobe 0x03 -> parity bit 0; stop bit follows each.
REQ-031 Assert rstn=0 in the middle of DATA -> uart_txd=1 with no clock edge, all flags 0, no tx_done; after release, strobe 0x55 -> a clean frame.
REQ-032 Full upstream frame pattern (0xFA, 0xF1, 128 data bytes, 0xF1, 0xFA at 2605-cycle spacing, default parameters) -> all 132 bytes received in order, overflow=0.
